det_window_counter: RTL and testbench
=====================================

DET_WINDOW_COUNTER -- requirements
Module: det_window_counter

Interface
REQ-001 SHALL have parameter WIN_CYCLES, default 16, the window length in clock cycles (legal range 2..256).
REQ-002 SHALL have parameter CNT_W, default 4, the width of the detection count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: enables windowed counting.
REQ-006 SHALL have port det, input, 1 bit: one-cycle detection pulse driven by the upstream 111/000 Mealy detector output y.
REQ-007 SHALL have port cnt_out, output, CNT_W bits: the detection count of the completed window.
REQ-008 SHALL have port cnt_valid, output, 1 bit: cnt_out holds a completed window result.
REQ-009 SHALL have port cnt_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port ovf, output, 1 bit: the reported count saturated.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, WINDOW, HOLD.
REQ-012 In IDLE, with en=1, SHALL clear the window timer and the running count and go to WINDOW on the next edge.
REQ-013 In IDLE, with en=0, SHALL remain in IDLE.
REQ-014 In WINDOW, SHALL sample det on every cycle; det=1 SHALL increment the running count by 1.
REQ-015 The running count SHALL saturate at 2^CNT_W-1; an increment attempted at saturation SHALL set the window overflow flag.
REQ-016 The window timer SHALL count 0..WIN_CYCLES-1.
REQ-017 On the cycle with timer==WIN_CYCLES-1, det SHALL still be counted, and the FSM SHALL go to HOLD.
REQ-018 On entry to HOLD, SHALL register cnt_out and ovf and assert cnt_valid; latency is 1 cycle after the last window cycle.
REQ-019 In HOLD, cnt_out, ovf and cnt_valid SHALL be stable until cnt_valid && cnt_ready.
REQ-020 det pulses arriving in HOLD SHALL be ignored.
REQ-021 On the HOLD handshake with en=1, SHALL go to WINDOW with timer, count and overflow cleared, giving back-to-back windows.
REQ-022 On the HOLD handshake with en=0, SHALL go to IDLE.
REQ-023 cnt_valid SHALL deassert on the edge that completes the handshake.
REQ-024 en=0 during WINDOW SHALL abort to IDLE on the next edge, with no result reported and the partial count discarded.
REQ-025 en=0 during HOLD SHALL NOT drop the pending result.
REQ-026 cnt_ready while cnt_valid=0 SHALL have no effect.
REQ-027 If det=1 and the timer wrap occur in the same cycle, the pulse SHALL be counted in the ending window.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, timer 0, running count 0, overflow flag 0, cnt_out 0, cnt_valid 0 and ovf 0.
REQ-029 Reset asserted mid-WINDOW or mid-HOLD SHALL discard all in-flight results.
REQ-030 After rst deasserts, the first window SHALL start no earlier than one edge after en=1 is sampled.

Structure
REQ-031 The state enum (IDLE, WINDOW, HOLD) and the default WIN_CYCLES/CNT_W constants SHALL live in shared package det_pkg.
REQ-032 The timer width SHALL be $clog2(WIN_CYCLES).
REQ-033 SHALL instantiate one sub-module, sat_counter (saturating CNT_W-bit counter with clear, inc and sat flag), for the running count.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Reset: rst=0 at t=0, released at 5 ns -> cnt_valid=0, cnt_out=0, ovf=0; FSM in IDLE until en=1.
REQ-036 Basic: WIN_CYCLES=16, en=1, det pulses in cycles 3, 9 and 12, cnt_ready=1 -> cnt_valid=1 for one cycle, 1 cycle after window cycle 15, with cnt_out=3 and ovf=0.
REQ-037 Saturation: CNT_W=4, det=1 for all 16 cycles -> cnt_out=15, ovf=1.
REQ-038 Backpressure: cnt_ready=0 for 5 cycles after cnt_valid, det pulsing -> cnt_out stable, det ignored; after the handshake the next window starts with count 0.
REQ-039 Abort: en=0 at window cycle 7 with count=2 -> no cnt_valid; the next window after en=1 reports only its own pulses.
REQ-040 End-to-end: drive the upstream detector with serial 1,0,0,0,1,0,1,1,1,0,1,1,1,1,0,0,0,0 into det -> cnt_out equals the detector's y pulse count within the window.

Source files
------------

// File: rtl/det_pkg.sv
// Shared constants and FSM state encoding for the windowed detection counter.
package det_pkg;

  localparam int WIN_CYCLES_DEF = 16;
  localparam int CNT_W_DEF      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WINDOW,
    HOLD
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/det_window_counter.sv
// Counts detector pulses over fixed windows and hands each window's total
// to a consumer through a valid/ready hold register.
module det_window_counter
  import det_pkg::*;
#(
  parameter int WIN_CYCLES = WIN_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             det,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             ovf
);

  localparam int            TW   = $clog2(WIN_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(WIN_CYCLES - 1);

  state_t           state;
  logic [TW-1:0]    timer;
  logic             ovf_flag;
  logic [CNT_W-1:0] run_cnt;
  logic             run_sat;
  logic             run_clr;
  logic             run_inc;
  logic [CNT_W-1:0] final_cnt;
  logic             hit_sat;

  // Outside WINDOW the running count is always idle at zero, so the next
  // window (fresh or back-to-back) never inherits a stale or aborted count.
  assign run_clr = (state != WINDOW);
  assign run_inc = (state == WINDOW) && en && det;
  assign hit_sat = det && run_sat;

  // The last window cycle's pulse is folded in here so the reported total
  // includes it without waiting an extra cycle for the counter to update.
  assign final_cnt = (det && !run_sat) ? run_cnt + 1'b1 : run_cnt;

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (run_inc),
    .cnt (run_cnt),
    .sat (run_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      ovf_flag  <= 1'b0;
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer    <= '0;
          ovf_flag <= 1'b0;
          if (en) state <= WINDOW;
        end
        WINDOW: begin
          if (!en) begin
            state    <= IDLE;
            timer    <= '0;
            ovf_flag <= 1'b0;
          end else begin
            if (hit_sat) ovf_flag <= 1'b1;
            if (timer == LAST) begin
              state     <= HOLD;
              timer     <= '0;
              cnt_out   <= final_cnt;
              ovf       <= ovf_flag | hit_sat;
              cnt_valid <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt_ready) begin
            cnt_valid <= 1'b0;
            timer     <= '0;
            ovf_flag  <= 1'b0;
            state     <= en ? WINDOW : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_det_window_counter.sv
// Directed scoreboard bench for det_window_counter (16-cycle window, 4-bit count).
`timescale 1ns/1ps
module tb_det_window_counter;

  typedef struct {
    logic [3:0] cnt;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b1;
  logic       rst;
  logic       en;
  logic       det;
  logic       cnt_ready;
  logic [3:0] cnt_out;
  logic       cnt_valid;
  logic       ovf;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t q[$];
  exp_t cur;
  logic have_cur   = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;

  int         serial [18] = '{1,0,0,0,1,0,1,1,1,0,1,1,1,1,0,0,0,0};
  logic       ys [18];
  logic [15:0] e2e_pat;

  det_window_counter #(
    .WIN_CYCLES(16),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .det       (det),
    .cnt_out   (cnt_out),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full window starting at window cycle 0; leaves the bench in the HOLD cycle.
  task automatic applyStimulus(input logic [15:0] pat, input logic [3:0] ecnt, input logic eovf);
    for (int i = 0; i < 16; i++) begin
      det = pat[i];
      if (i == 15) q.push_back('{ecnt, eovf, cyc + 1});
      step();
    end
    det = 1'b0;
  endtask

  // Monitor: every cycle with cnt_valid high is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (prev_hs) checkOutput("valid_drop", {31'd0, cnt_valid}, 32'd0);
      if (cnt_valid === 1'b1) begin
        if (!prev_valid) begin
          if (q.size() == 0) begin
            checkOutput("unexpected_valid", {31'd0, cnt_valid}, 32'd0);
            have_cur = 1'b0;
          end else begin
            cur      = q.pop_front();
            have_cur = 1'b1;
            checkOutput("valid_cycle", cyc, cur.cyc);
          end
        end
        if (have_cur) begin
          checkOutput("cnt_out", {28'd0, cnt_out}, {28'd0, cur.cnt});
          checkOutput("ovf", {31'd0, ovf}, {31'd0, cur.ovf});
        end
      end else begin
        have_cur = 1'b0;
      end
      prev_hs    = cnt_valid && cnt_ready;
      prev_valid = cnt_valid;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      have_cur   = 1'b0;
    end
  end

  initial begin
    logic [1:0] h;
    h = 2'b00;
    for (int i = 0; i < 18; i++) begin
      ys[i] = (i >= 2) && ((h == 2'b11 && serial[i] == 1) || (h == 2'b00 && serial[i] == 0));
      h = {h[0], serial[i][0]};
    end
    for (int i = 0; i < 16; i++) e2e_pat[i] = ys[i];

    rst       = 1'b0;
    en        = 1'b0;
    det       = 1'b0;
    cnt_ready = 1'b0;
    #2;
    checkOutput("reset_valid", {31'd0, cnt_valid}, 32'd0);
    checkOutput("reset_cnt", {28'd0, cnt_out}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
    #3 rst = 1'b1;

    repeat (3) step();
    checkOutput("idle_valid", {31'd0, cnt_valid}, 32'd0);

    $display("[TB] basic window");
    cnt_ready = 1'b1;
    en = 1'b1; step();
    applyStimulus(16'h1208, 4'd3, 1'b0);
    en = 1'b0; step();

    $display("[TB] saturation");
    en = 1'b1; step();
    applyStimulus(16'hFFFF, 4'd15, 1'b1);
    en = 1'b0; step();

    $display("[TB] backpressure and back-to-back");
    cnt_ready = 1'b0;
    en = 1'b1; step();
    applyStimulus(16'h0101, 4'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      det = (i % 2 == 0);
      en  = (i != 2);
      step();
    end
    det = 1'b0; en = 1'b1; cnt_ready = 1'b1; step();
    applyStimulus(16'h0010, 4'd1, 1'b0);
    en = 1'b0; step();

    $display("[TB] abort");
    en = 1'b1; step();
    for (int i = 0; i < 7; i++) begin
      det = (i == 2 || i == 5);
      step();
    end
    det = 1'b0; en = 1'b0; step();
    repeat (20) step();
    checkOutput("abort_no_valid", {31'd0, cnt_valid}, 32'd0);
    en = 1'b1; step();
    applyStimulus(16'h8000, 4'd1, 1'b0);
    en = 1'b0; step();

    $display("[TB] end-to-end detector");
    en = 1'b1; step();
    applyStimulus(e2e_pat, 4'd4, 1'b0);
    det = ys[16]; en = 1'b0; step();
    det = ys[17]; step();
    det = 1'b0;

    $display("[TB] reset mid-window");
    en = 1'b1; step();
    det = 1'b1; repeat (5) step();
    rst = 1'b0; #2;
    checkOutput("rst_win_valid", {31'd0, cnt_valid}, 32'd0);
    checkOutput("rst_win_cnt", {28'd0, cnt_out}, 32'd0);
    en = 1'b0; det = 1'b0; rst = 1'b1;
    repeat (3) step();

    $display("[TB] reset mid-hold");
    cnt_ready = 1'b0;
    en = 1'b1; step();
    applyStimulus(16'h0006, 4'd2, 1'b0);
    step();
    rst = 1'b0; #2;
    checkOutput("rst_hold_valid", {31'd0, cnt_valid}, 32'd0);
    checkOutput("rst_hold_cnt", {28'd0, cnt_out}, 32'd0);
    en = 1'b0; rst = 1'b1;
    repeat (20) step();

    checkOutput("pending_results", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
